// File: rtl/ibram_pkg.sv
// ibram_pkg: shared types and helpers for the instruction-RAM port arbiter.
//   state_t    - loader RMW sequencer states
//   merge_half - insert a 32-bit loader beat into one half of a 64-bit word
package ibram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  // sel=0 replaces [31:0], sel=1 replaces [63:32]
  function automatic logic [63:0] merge_half(input logic [63:0] old64,
                                             input logic [31:0] data32,
                                             input logic        sel);
    merge_half = sel ? {data32, old64[31:0]} : {old64[63:32], data32};
  endfunction

endpackage

// File: rtl/ibram_port_arbiter.sv
// ibram_port_arbiter: shares the single read port of the 64-bit instruction
// RAM between instruction fetch and a 32-bit loader/debug write stream.
// Loader beats are applied as read-modify-write sequences (IDLE -> RD_REQ ->
// RD_WAIT), since the RAM has no byte/half enables.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fetch_req_i/addr_i  fetch read request (must be held until granted)
//   fetch_gnt_o         fetch read issued this cycle (combinational)
//   fetch_rvalid_o      fetch data valid, one cycle after grant
//   fetch_rdata_o       fetch read data
//   ld_valid_i/ready_o  loader beat handshake
//   ld_addr_i, ld_data_i loader 32-bit word index (bit0 = half) and data
//   ram_rd_*            RAM read port (registered data, 1-cycle latency)
//   ram_wr_*            RAM write port
//
// Optional build macro IBRAM_WR_FWD_EN: when defined, a fetch granted in the
// same cycle as a write to the same word returns the newly written data
// instead of the RAM's read-before-write old data.
module ibram_port_arbiter
  import ibram_pkg::*;
#(
  parameter int unsigned SIZE       = 8192,
  parameter int unsigned STARVE_MAX = 8,
  localparam int unsigned AW        = $clog2(SIZE) - 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [63:0]   fetch_rdata_o,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  input  logic [AW:0]   ld_addr_i,
  input  logic [31:0]   ld_data_i,
  output logic          ram_rd_en_o,
  output logic [AW-1:0] ram_rd_addr_o,
  input  logic [63:0]   ram_rd_data_i,
  output logic          ram_wr_en_o,
  output logic [AW-1:0] ram_wr_addr_o,
  output logic [63:0]   ram_wr_data_o
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic [AW:0]   held_addr;
  logic [31:0]   held_data;
  logic          ld_rd;

  // Loader takes the read port in RD_REQ unless fetch still has credit left.
  always_comb begin
    ld_rd = (state == RD_REQ) && !(fetch_req_i && (starve_cnt < STARVE_LIM));
  end

  always_comb begin
    fetch_gnt_o   = fetch_req_i & ~ld_rd;
    ram_rd_en_o   = fetch_gnt_o | ld_rd;
    ram_rd_addr_o = ld_rd ? held_addr[AW:1] : fetch_addr_i;
    ram_wr_en_o   = (state == RD_WAIT);
    ram_wr_addr_o = held_addr[AW:1];
    ram_wr_data_o = merge_half(ram_rd_data_i, held_data, held_addr[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      fetch_rvalid_o <= 1'b0;
      ld_ready_o     <= 1'b1;
      held_addr      <= '0;
      held_data      <= '0;
    end else begin
      fetch_rvalid_o <= fetch_gnt_o;
      case (state)
        IDLE: begin
          if (ld_valid_i) begin
            held_addr  <= ld_addr_i;
            held_data  <= ld_data_i;
            starve_cnt <= '0;
            ld_ready_o <= 1'b0;
            state      <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (ld_rd) begin
            starve_cnt <= '0;
            state      <= RD_WAIT;
          end else begin
            starve_cnt <= starve_cnt + CW'(1);
          end
        end
        RD_WAIT: begin
          ld_ready_o <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          ld_ready_o <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef IBRAM_WR_FWD_EN
  logic        fwd_hit;
  logic [63:0] fwd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= fetch_gnt_o & ram_wr_en_o & (fetch_addr_i == ram_wr_addr_o);
      fwd_data <= ram_wr_data_o;
    end
  end

  always_comb begin
    fetch_rdata_o = fwd_hit ? fwd_data : ram_rd_data_i;
  end
`else
  always_comb begin
    fetch_rdata_o = ram_rd_data_i;
  end
`endif

endmodule

// File: tb/tb_ibram_port_arbiter.sv
// Testbench for ibram_port_arbiter with a behavioural read-before-write RAM.
module tb_ibram_port_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [63:0]   fetch_rdata;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW:0]   ld_addr;
  logic [31:0]   ld_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [63:0]   ram_rd_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [63:0]   ram_wr_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [63:0]   d;
  } wr_t;

  wr_t         wq[$];       // expected RAM writes, in order
  logic [63:0] rq[$];       // expected fetch read data, in order
  logic [63:0] cmem [0:1023];  // expected committed RAM contents
  logic [63:0] emem [0:1023];  // expected contents including queued beats
  logic [63:0] ram  [0:1023];  // environment RAM written by the DUT

  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [63:0]   pl_d;

  logic          s_gnt, s_ready, s_wren, s_rden;
  logic [AW-1:0] s_rdaddr;
  logic [63:0]   s_rdata;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else begin
      if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
      if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    end
  end

  ibram_port_arbiter #(.SIZE(8192), .STARVE_MAX(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req_i   (fetch_req),
    .fetch_addr_i  (fetch_addr),
    .fetch_gnt_o   (fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid),
    .fetch_rdata_o (fetch_rdata),
    .ld_valid_i    (ld_valid),
    .ld_ready_o    (ld_ready),
    .ld_addr_i     (ld_addr),
    .ld_data_i     (ld_data),
    .ram_rd_en_o   (ram_rd_en),
    .ram_rd_addr_o (ram_rd_addr),
    .ram_rd_data_i (ram_rd_data),
    .ram_wr_en_o   (ram_wr_en),
    .ram_wr_addr_o (ram_wr_addr),
    .ram_wr_data_o (ram_wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Per-cycle scoreboard, sampled at the falling edge.
  task automatic mon();
    logic [63:0] d;
    wr_t w;
    s_gnt    = fetch_gnt;
    s_ready  = ld_ready;
    s_wren   = ram_wr_en;
    s_rden   = ram_rd_en;
    s_rdaddr = ram_rd_addr;
    s_rdata  = fetch_rdata;
    if (rq.size() > 0) begin
      d = rq.pop_front();
      chk("rvalid", {63'd0, fetch_rvalid}, 64'd1);
      chk("rdata", fetch_rdata, d);
    end else begin
      chk("rvalid_idle", {63'd0, fetch_rvalid}, 64'd0);
    end
    if (fetch_gnt) begin
      chk("gnt_without_req", {63'd0, fetch_req}, 64'd1);
      d = cmem[fetch_addr];
`ifdef IBRAM_WR_FWD_EN
      if (ram_wr_en && wq.size() > 0 && wq[0].a == fetch_addr) d = wq[0].d;
`endif
      rq.push_back(d);
    end
    if (ram_wr_en) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", {54'd0, ram_wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", {54'd0, ram_wr_addr}, {54'd0, w.a});
        chk("wr_data", ram_wr_data, w.d);
        cmem[w.a] = w.d;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [AW:0] a, input logic [31:0] d);
    wr_t w;
    logic [63:0] base;
    w.a  = a[AW:1];
    base = emem[w.a];
    w.d  = a[0] ? {d, base[31:0]} : {base[63:32], d};
    emem[w.a] = w.d;
    wq.push_back(w);
  endtask

  task automatic send_beat(input logic [AW:0] a, input logic [31:0] d);
    logic got;
    push_beat(a, d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    got      = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      got = s_ready;
    end
    chk("beat_accept", {63'd0, got}, 64'd1);
    ld_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    wr_t tmp;
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    ld_valid   = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    pl_en      = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      cmem[i] = '0;
      emem[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      pl_a = AW'(i);
      if (i == 5)      pl_d = 64'hAAAA_AAAA_BBBB_BBBB;
      else if (i == 6) pl_d = 64'h6666_6666_7777_7777;
      else             pl_d = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
      cmem[i] = pl_d;
      emem[i] = pl_d;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;

    // Reset state
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("rst_rvalid", {63'd0, fetch_rvalid}, 64'd0);
    chk("rst_wr_en", {63'd0, ram_wr_en}, 64'd0);
    chk("rst_gnt", {63'd0, fetch_gnt}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // Single half-word RMW into the upper half of word 5
    push_beat(11, 32'h1234_5678);
    ld_valid = 1'b1; ld_addr = 11; ld_data = 32'h1234_5678;
    cyc();
    chk("t1_accept_ready", {63'd0, s_ready}, 64'd1);
    chk("t1_accept_wren", {63'd0, s_wren}, 64'd0);
    ld_valid = 1'b0;
    cyc();
    chk("t1_req_ready", {63'd0, s_ready}, 64'd0);
    chk("t1_req_rden", {63'd0, s_rden}, 64'd1);
    chk("t1_req_rdaddr", {54'd0, s_rdaddr}, 64'd5);
    chk("t1_req_wren", {63'd0, s_wren}, 64'd0);
    cyc();
    chk("t1_wait_ready", {63'd0, s_ready}, 64'd0);
    chk("t1_wait_wren", {63'd0, s_wren}, 64'd1);
    cyc();
    chk("t1_done_ready", {63'd0, s_ready}, 64'd1);
    chk("t1_done_wren", {63'd0, s_wren}, 64'd0);
    chk("t1_ram5", ram[5], 64'h1234_5678_BBBB_BBBB);

    // Starvation limit: fetch held high wins 8 RD_REQ cycles, loader the 9th
    fetch_req = 1'b1; fetch_addr = 2;
    push_beat(0, 32'h0BAD_F00D);
    ld_valid = 1'b1; ld_addr = 0; ld_data = 32'h0BAD_F00D;
    cyc();
    chk("t2_accept_gnt", {63'd0, s_gnt}, 64'd1);
    chk("t2_accept_ready", {63'd0, s_ready}, 64'd1);
    ld_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t2_fetch_wins", {63'd0, s_gnt}, 64'd1);
    end
    cyc();
    chk("t2_loader_gnt", {63'd0, s_gnt}, 64'd0);
    chk("t2_loader_rden", {63'd0, s_rden}, 64'd1);
    chk("t2_loader_rdaddr", {54'd0, s_rdaddr}, 64'd0);
    cyc();
    chk("t2_wait_gnt", {63'd0, s_gnt}, 64'd1);
    chk("t2_wait_wren", {63'd0, s_wren}, 64'd1);
    fetch_req = 1'b0;
    cyc();

    // Back-to-back beats to both halves of word 5
    send_beat(10, 32'h0000_0001);
    send_beat(11, 32'h0000_0002);
    cyc(); cyc(); cyc();
    chk("t3_ram5", ram[5], 64'h0000_0002_0000_0001);
    fetch_req = 1'b1; fetch_addr = 5;
    cyc();
    fetch_req = 1'b0;
    cyc();
    chk("t3_fetch5", s_rdata, 64'h0000_0002_0000_0001);

    // Fetch of word 5 in the same cycle as its write
    push_beat(10, 32'h0000_CAFE);
    ld_valid = 1'b1; ld_addr = 10; ld_data = 32'h0000_CAFE;
    cyc();
    ld_valid = 1'b0;
    cyc();
    fetch_req = 1'b1; fetch_addr = 5;
    cyc();
    chk("t4_gnt", {63'd0, s_gnt}, 64'd1);
    chk("t4_wren", {63'd0, s_wren}, 64'd1);
    fetch_req = 1'b0;
    cyc();
`ifdef IBRAM_WR_FWD_EN
    chk("t4_same_word", s_rdata, 64'h0000_0002_0000_CAFE);
`else
    chk("t4_same_word", s_rdata, 64'h0000_0002_0000_0001);
`endif
    chk("t4_ram5", ram[5], 64'h0000_0002_0000_CAFE);

    // Reset while in RD_REQ drops the held beat
    push_beat(12, 32'hDEAD_BEEF);
    ld_valid = 1'b1; ld_addr = 12; ld_data = 32'hDEAD_BEEF;
    cyc();
    ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", {63'd0, ld_ready}, 64'd1);
    chk("t5_rst_wren", {63'd0, ram_wr_en}, 64'd0);
    tmp = wq.pop_back();
    emem[tmp.a] = cmem[tmp.a];
    rq.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("t5_ready_after", {63'd0, s_ready}, 64'd1);
    chk("t5_ram6", ram[6], 64'h6666_6666_7777_7777);

    // Idle loader, fetch streaming words 0..3
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_addr = AW'(i);
      cyc();
      chk("t6_gnt", {63'd0, s_gnt}, 64'd1);
    end
    fetch_req = 1'b0;
    cyc();
    cyc();
    chk("end_wq_empty", 64'(wq.size()), 64'd0);
    chk("end_rq_empty", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
